display_source_mux: RTL and testbench

- Parametrised successor to the fixed three-way display selector in the range-hood top level.
- Selects one of N_CH segment-data sources (power-on time, work time, gesture time, ...) for the two 8-bit digit banks, and drives the digit-scan strobes.
- Adds next/prev key stepping with wrap-around, timed auto-rotation, an alert override that forces a channel (cleaning reminder), and blanking while power is off.
- Sits between the timer/mode blocks and the seven-segment pins.

---
 rtl/hood_disp_pkg.sv | 30 +++
 rtl/key_edge_sync.sv | 41 ++++
 rtl/display_source_mux.sv | 176 +++++++++++++++++
 tb/tb_display_source_mux.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hood_disp_pkg.sv
// -----------------------------------------------------------------------------
// hood_disp_pkg
// Shared definitions for the range-hood display path: the blank segment
// pattern, the default source-channel indices and the digit-strobe helper.
// -----------------------------------------------------------------------------
package hood_disp_pkg;

   localparam logic [7:0] SEG_BLANK = 8'h00;

   // Default meaning of the display sources in the hood top level.
   localparam int CH_POWER_TIME   = 0;
   localparam int CH_WORK_TIME    = 1;
   localparam int CH_GESTURE_TIME = 2;

   // Digit strobe pattern for scan position idx: one digit in each bank is
   // lit at the same time, bank 2 being offset by half the digit count.
   function automatic logic [7:0] onehot_pair(input int unsigned idx,
                                              input int unsigned digits);
      logic [7:0]  pat;
      int unsigned hi;
      pat = SEG_BLANK;
      hi  = idx + digits / 2;
      if (digits <= 8 && idx < digits / 2) begin
         pat[idx[2:0]] = 1'b1;
         pat[hi[2:0]]  = 1'b1;
      end
      return pat;
   endfunction

endpackage

// File: rtl/key_edge_sync.sv
// -----------------------------------------------------------------------------
// key_edge_sync
// Brings a raw asynchronous key level into the clk domain through two flops
// and emits a single-cycle pulse on its rising edge. A held key yields one
// pulse only.
//
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous, active-high reset
//   key    in   raw key level
//   pulse  out  one-cycle pulse, valid after the 2nd edge sampling key high
// -----------------------------------------------------------------------------
module key_edge_sync (
   input  logic clk,
   input  logic reset,
   input  logic key,
   output logic pulse
);

   logic sync_1;
   logic sync_2;
   logic sync_3;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbour, forming a true shift chain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
         sync_3 <= 1'b0;
      end else begin
         sync_1 <= key;
         sync_2 <= sync_1;
         sync_3 <= sync_2;
      end
   end

   // sync_3 is the previous synchronized level; high-now, low-before is a rise.
   assign pulse = sync_2 & ~sync_3;

endmodule

// File: rtl/display_source_mux.sv
// -----------------------------------------------------------------------------
// display_source_mux
// Chooses one of N_CH segment-data sources for the two seven-segment digit
// banks and scans the digits. The channel is stepped with next/prev keys
// (wrapping), rotated automatically in auto mode, forced to ALERT_CH while
// alert is high, and everything is blanked while the appliance is off.
//
// Ports:
//   clk             in   system clock
//   reset           in   asynchronous, active-high reset
//   power_state     in   high = appliance on
//   next_key        in   raw key level, rising edge steps forward
//   prev_key        in   raw key level, rising edge steps back
//   auto_mode       in   high = timed rotation through the channels
//   alert           in   high = force ALERT_CH onto the display
//   src_segments    in   channel ch, digit d at [(ch*DIGITS+d)*8 +: 8]
//   tub_segments_1  out  segment pattern for bank 1 (digits 0..DIGITS/2-1)
//   tub_segments_2  out  segment pattern for bank 2 (remaining digits)
//   tub_select      out  active-high digit strobes
//   active_ch       out  channel currently displayed
// -----------------------------------------------------------------------------
module display_source_mux
   import hood_disp_pkg::*;
#(
   parameter int N_CH         = 3,
   parameter int DIGITS       = 8,
   parameter int SCAN_DIV     = 100000,
   parameter int DWELL_CYCLES = 300000000,
   parameter int ALERT_CH     = CH_WORK_TIME,
   parameter int CH_W         = $clog2(N_CH)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       power_state,
   input  logic                       next_key,
   input  logic                       prev_key,
   input  logic                       auto_mode,
   input  logic                       alert,
   input  logic [N_CH*DIGITS*8-1:0]   src_segments,
   output logic [7:0]                 tub_segments_1,
   output logic [7:0]                 tub_segments_2,
   output logic [DIGITS-1:0]          tub_select,
   output logic [CH_W-1:0]            active_ch
);

   localparam int HALF  = DIGITS / 2;
   localparam int IDX_W = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DW_W  = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

   if (N_CH < 2) begin : g_bad_n_ch
      $error("display_source_mux: N_CH must be at least 2");
   end
   if ((DIGITS % 2) != 0 || DIGITS < 2 || DIGITS > 8) begin : g_bad_digits
      $error("display_source_mux: DIGITS must be even and within 2..8");
   end
   if (ALERT_CH >= N_CH) begin : g_bad_alert_ch
      $error("display_source_mux: ALERT_CH must be below N_CH");
   end

   // ---------------------------------------------------------------- keys
   logic next_pulse;
   logic prev_pulse;

   key_edge_sync u_next_sync (
      .clk   (clk),
      .reset (reset),
      .key   (next_key),
      .pulse (next_pulse)
   );

   key_edge_sync u_prev_sync (
      .clk   (clk),
      .reset (reset),
      .key   (prev_key),
      .pulse (prev_pulse)
   );

   // ------------------------------------------------------ channel select
   logic [CH_W-1:0] sel_ch;
   logic [CH_W-1:0] ch_fwd;
   logic [CH_W-1:0] ch_back;
   logic [DW_W-1:0] dwell;

   // NOTE: every always_comb output gets a value on every path (here by the
   // conditional operator) so no latch is inferred.
   always_comb begin
      ch_fwd  = (sel_ch == CH_W'(N_CH - 1)) ? '0 : sel_ch + CH_W'(1);
      ch_back = (sel_ch == '0) ? CH_W'(N_CH - 1) : sel_ch - CH_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sel_ch <= '0;
         dwell  <= '0;
      end else if (!power_state) begin
         sel_ch <= '0;
         dwell  <= '0;
      end else if (alert) begin
         // Frozen so the user's channel reappears once the alert clears.
         sel_ch <= sel_ch;
         dwell  <= dwell;
      end else if (next_pulse && prev_pulse) begin
         sel_ch <= '0;
         dwell  <= '0;
      end else if (next_pulse) begin
         sel_ch <= ch_fwd;
         dwell  <= '0;
      end else if (prev_pulse) begin
         sel_ch <= ch_back;
         dwell  <= '0;
      end else if (auto_mode) begin
         if (dwell == DW_W'(DWELL_CYCLES - 1)) begin
            sel_ch <= ch_fwd;
            dwell  <= '0;
         end else begin
            dwell <= dwell + DW_W'(1);
         end
      end else begin
         dwell <= '0;
      end
   end

   // ---------------------------------------------------------------- scan
   logic [DIV_W-1:0] scan_div;
   logic [IDX_W-1:0] scan_idx;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scan_div <= '0;
         scan_idx <= '0;
      end else if (!power_state) begin
         scan_div <= '0;
         scan_idx <= '0;
      end else if (scan_div == DIV_W'(SCAN_DIV - 1)) begin
         scan_div <= '0;
         scan_idx <= (scan_idx == IDX_W'(HALF - 1)) ? '0 : scan_idx + IDX_W'(1);
      end else begin
         scan_div <= scan_div + DIV_W'(1);
      end
   end

   // -------------------------------------------------------- segment path
   int         seg_lo_idx;
   logic [7:0] seg_lo;
   logic [7:0] seg_hi;
   logic [7:0] pair_pat;

   // Source data is read live from the currently displayed channel.
   always_comb begin
      seg_lo_idx = int'(active_ch) * DIGITS + int'(scan_idx);
      seg_lo     = src_segments[seg_lo_idx * 8 +: 8];
      seg_hi     = src_segments[(seg_lo_idx + HALF) * 8 +: 8];
      pair_pat   = onehot_pair(int'(scan_idx), DIGITS);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         active_ch      <= '0;
         tub_select     <= '0;
         tub_segments_1 <= SEG_BLANK;
         tub_segments_2 <= SEG_BLANK;
      end else if (!power_state) begin
         active_ch      <= '0;
         tub_select     <= '0;
         tub_segments_1 <= SEG_BLANK;
         tub_segments_2 <= SEG_BLANK;
      end else begin
         active_ch      <= alert ? CH_W'(ALERT_CH) : sel_ch;
         tub_select     <= pair_pat[DIGITS-1:0];
         tub_segments_1 <= seg_lo;
         tub_segments_2 <= seg_hi;
      end
   end

endmodule

// File: tb/tb_display_source_mux.sv
// -----------------------------------------------------------------------------
// tb_display_source_mux
// Scoreboard bench: a reference model steps on every clk edge from the
// input levels and queues the expected registered outputs; a monitor on the
// falling edge pops and compares. Directed phases follow the intended use,
// then a randomized phase mixes keys, alert, auto mode, power and data.
// -----------------------------------------------------------------------------
module tb_display_source_mux;

   localparam int N_CH         = 3;
   localparam int DIGITS       = 8;
   localparam int SCAN_DIV     = 4;
   localparam int DWELL_CYCLES = 20;
   localparam int ALERT_CH     = 1;
   localparam int CH_W         = $clog2(N_CH);
   localparam int HALF         = DIGITS / 2;

   logic                     clk = 1'b0;
   logic                     reset;
   logic                     power_state;
   logic                     next_key;
   logic                     prev_key;
   logic                     auto_mode;
   logic                     alert;
   logic [N_CH*DIGITS*8-1:0] src_segments;
   logic [7:0]               tub_segments_1;
   logic [7:0]               tub_segments_2;
   logic [DIGITS-1:0]        tub_select;
   logic [CH_W-1:0]          active_ch;

   display_source_mux #(
      .N_CH         (N_CH),
      .DIGITS       (DIGITS),
      .SCAN_DIV     (SCAN_DIV),
      .DWELL_CYCLES (DWELL_CYCLES),
      .ALERT_CH     (ALERT_CH)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .power_state    (power_state),
      .next_key       (next_key),
      .prev_key       (prev_key),
      .auto_mode      (auto_mode),
      .alert          (alert),
      .src_segments   (src_segments),
      .tub_segments_1 (tub_segments_1),
      .tub_segments_2 (tub_segments_2),
      .tub_select     (tub_select),
      .active_ch      (active_ch)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] sel;
      logic [7:0] s1;
      logic [7:0] s2;
      logic [7:0] ch;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [7:0] src_byte(input int ch, input int d);
      logic [N_CH*DIGITS*8-1:0] tmp;
      tmp = src_segments >> ((ch * DIGITS + d) * 8);
      return tmp[7:0];
   endfunction

   // ------------------------------------------------------ reference model
   // m_scan_n counts consecutive powered edges; the scan position is simply
   // that count divided down. Key histories hold samples from the last three
   // edges: a pulse acts when the key was first seen high two edges ago.
   int m_sel, m_dwell, m_active, m_scan_n;
   int nk[1:3];
   int pk[1:3];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_sel    = 0;
         m_dwell  = 0;
         m_active = 0;
         m_scan_n = 0;
         for (int i = 1; i <= 3; i++) begin
            nk[i] = 0;
            pk[i] = 0;
         end
      end else begin : model_step
         exp_t e;
         int   idx;
         bit   np, pp;
         np = (nk[2] == 1) && (nk[3] == 0);
         pp = (pk[2] == 1) && (pk[3] == 0);
         e  = '0;
         if (power_state) begin
            idx   = (m_scan_n / SCAN_DIV) % HALF;
            e.sel = 8'((1 << idx) | (1 << (idx + HALF)));
            e.s1  = src_byte(m_active, idx);
            e.s2  = src_byte(m_active, idx + HALF);
            e.ch  = alert ? 8'(ALERT_CH) : 8'(m_sel);
         end
         m_active = int'(e.ch);
         m_scan_n = power_state ? m_scan_n + 1 : 0;
         if (!power_state) begin
            m_sel   = 0;
            m_dwell = 0;
         end else if (alert) begin
            // channel and dwell frozen
         end else if (np && pp) begin
            m_sel   = 0;
            m_dwell = 0;
         end else if (np) begin
            m_sel   = (m_sel + 1) % N_CH;
            m_dwell = 0;
         end else if (pp) begin
            m_sel   = (m_sel + N_CH - 1) % N_CH;
            m_dwell = 0;
         end else if (auto_mode) begin
            m_dwell++;
            if (m_dwell == DWELL_CYCLES) begin
               m_sel   = (m_sel + 1) % N_CH;
               m_dwell = 0;
            end
         end else begin
            m_dwell = 0;
         end
         nk[3] = nk[2]; nk[2] = nk[1]; nk[1] = int'(next_key);
         pk[3] = pk[2]; pk[2] = pk[1]; pk[1] = int'(prev_key);
         exp_q.push_back(e);
      end
   end

   // -------------------------------------------------------------- monitor
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin : mon_step
         exp_t e;
         e = exp_q.pop_front();
         check("tub_select",     32'(tub_select),     32'(e.sel));
         check("tub_segments_1", 32'(tub_segments_1), 32'(e.s1));
         check("tub_segments_2", 32'(tub_segments_2), 32'(e.s2));
         check("active_ch",      32'(active_ch),      32'(e.ch));
      end
   end

   // ------------------------------------------------------------- stimulus
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input bit nxt, input bit prv, input int hold);
      next_key = nxt;
      prev_key = prv;
      tick(hold);
      next_key = 1'b0;
      prev_key = 1'b0;
      tick(5);
   endtask

   task automatic check_blank(input string tag);
      check({tag, "_tub_select"}, 32'(tub_select), 32'h0);
      check({tag, "_seg_1"},      32'(tub_segments_1), 32'h0);
      check({tag, "_seg_2"},      32'(tub_segments_2), 32'h0);
      check({tag, "_active_ch"},  32'(active_ch), 32'h0);
   endtask

   initial begin
      bit found;
      reset       = 1'b1;
      power_state = 1'b1;
      next_key    = 1'b0;
      prev_key    = 1'b0;
      auto_mode   = 1'b0;
      alert       = 1'b0;
      for (int c = 0; c < N_CH; c++)
         for (int d = 0; d < DIGITS; d++)
            src_segments[(c*DIGITS+d)*8 +: 8] = 8'((c + 1) * 16 + d);
      tick(3);
      check_blank("reset");
      reset = 1'b0;

      // scan walk: bank pair 1/5 shows ch0 digits 1 and 5
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick(1);
         if (tub_select == 8'h22) found = 1'b1;
      end
      check("scan_reaches_22", 32'(found), 32'd1);
      check("scan22_seg_1", 32'(tub_segments_1), 32'h11);
      check("scan22_seg_2", 32'(tub_segments_2), 32'h15);

      // key stepping with wrap
      press(1, 0, 10); check("next_1", 32'(active_ch), 32'd1);
      press(1, 0, 10); check("next_2", 32'(active_ch), 32'd2);
      press(1, 0, 10); check("next_3", 32'(active_ch), 32'd0);
      press(0, 1, 10); check("prev_wrap", 32'(active_ch), 32'd2);
      press(1, 1, 10); check("both_home", 32'(active_ch), 32'd0);

      // auto rotation, then a key press part-way through a dwell
      auto_mode = 1'b1;
      tick(70);
      auto_mode = 1'b0;
      tick(1);
      auto_mode = 1'b1;
      tick(10);
      press(1, 0, 3);
      tick(30);
      auto_mode = 1'b0;
      tick(2);

      // alert override from channel 2
      for (int i = 0; i < N_CH && active_ch != 2; i++) press(1, 0, 4);
      check("pre_alert_ch2", 32'(active_ch), 32'd2);
      alert = 1'b1;
      tick(1);
      check("alert_forced", 32'(active_ch), 32'(ALERT_CH));
      press(1, 0, 6);
      check("alert_key_ignored", 32'(active_ch), 32'(ALERT_CH));
      alert = 1'b0;
      tick(1);
      check("alert_released", 32'(active_ch), 32'd2);

      // power off mid-scan, keys ignored, re-power restarts on ch0
      tick(6);
      power_state = 1'b0;
      tick(1);
      check_blank("power_off");
      press(1, 0, 10);
      check_blank("power_off_key");
      power_state = 1'b1;
      tick(1);
      check("repower_tub", 32'(tub_select), 32'h11);
      check("repower_ch",  32'(active_ch), 32'd0);

      // asynchronous reset between clock edges, mid-dwell
      press(1, 0, 4);
      auto_mode = 1'b1;
      tick(7);
      #2 reset = 1'b1;
      #1 check_blank("async_reset");
      tick(2);
      reset = 1'b0;
      tick(4);

      // randomized mix
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if ($urandom_range(0, 7) == 0) next_key = ~next_key;
         if ($urandom_range(0, 7) == 0) prev_key = ~prev_key;
         if ($urandom_range(0, 59) == 0) alert = ~alert;
         if ($urandom_range(0, 99) == 0) auto_mode = ~auto_mode;
         if ($urandom_range(0, 199) == 0) power_state = ~power_state;
         if (!power_state && $urandom_range(0, 9) == 0) power_state = 1'b1;
         if ($urandom_range(0, 15) == 0)
            src_segments[$urandom_range(0, N_CH*DIGITS-1)*8 +: 8] = 8'($urandom);
         tick(1);
      end

      tick(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
